// File: rtl/addr_mult_pkg.sv
// Shared constants, tag type and stage-count helper for the A-register address multiplier.
package addr_mult_pkg;

  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned ADDR_PP   = 4;
  localparam int unsigned ADDR_TAGW = 3;

  typedef logic [ADDR_TAGW-1:0] addr_tag_t;

  function automatic int unsigned addr_mult_nstg(input int unsigned w, input int unsigned pp);
    return w / pp;
  endfunction

endpackage

// File: rtl/addr_mult_stage.sv
// One multiplier pipeline stage: adds PP partial products of aj selected by its slice of ak.
module addr_mult_stage #(
  parameter int unsigned W     = 24,
  parameter int unsigned PP    = 4,
  parameter int unsigned TAGW  = 3,
  parameter int unsigned AccW  = 24,
  parameter int unsigned Stage = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [TAGW-1:0] tag_i,
  input  logic [W-1:0]    aj_i,
  input  logic [W-1:0]    ak_i,
  input  logic [AccW-1:0] acc_i,
  output logic            valid_o,
  output logic [TAGW-1:0] tag_o,
  output logic [W-1:0]    aj_o,
  output logic [W-1:0]    ak_o,
  output logic [AccW-1:0] acc_o
);

  localparam int unsigned Base = (Stage - 1) * PP;

  logic            valid_q;
  logic [TAGW-1:0] tag_q;
  logic [W-1:0]    aj_q;
  logic [W-1:0]    ak_q;
  logic [AccW-1:0] acc_q;
  logic [AccW-1:0] acc_d;

  // Shifting within AccW bits drops the upper partial-product bits in the W-wide build.
  always_comb begin
    acc_d = acc_i;
    for (int unsigned j = 0; j < PP; j++) begin
      if (ak_i[Base + j]) begin
        acc_d = acc_d + (AccW'(aj_i) << (Base + j));
      end
    end
  end

  // Data registers hold unless a live operation arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      aj_q    <= '0;
      ak_q    <= '0;
      acc_q   <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        tag_q <= tag_i;
        aj_q  <= aj_i;
        ak_q  <= ak_i;
        acc_q <= acc_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign aj_o    = aj_q;
  assign ak_o    = ak_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/addr_mult_pipe.sv
// Fully pipelined W x W address multiplier, W/PP stages, in-order retire with flush.
// Define ADDR_MULT_OVF_EN for 2W-bit accumulators and the o_ovf output.
module addr_mult_pipe
  import addr_mult_pkg::*;
#(
  parameter int unsigned W    = ADDR_W,
  parameter int unsigned PP   = ADDR_PP,
  parameter int unsigned TAGW = ADDR_TAGW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [W-1:0]    i_aj,
  input  logic [W-1:0]    i_ak,
  input  logic [TAGW-1:0] i_tag,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [W-1:0]    o_result,
  output logic [TAGW-1:0] o_tag,
`ifdef ADDR_MULT_OVF_EN
  output logic            o_ovf,
`endif
  output logic            o_busy
);

  localparam int unsigned NSTG = addr_mult_nstg(W, PP);
`ifdef ADDR_MULT_OVF_EN
  localparam int unsigned AccW = 2 * W;
`else
  localparam int unsigned AccW = W;
`endif

  if (W % PP != 0) begin : g_cfg_err
    $error("addr_mult_pipe: W must be a multiple of PP");
  end

  // Index 0 is the issue port; index k is the output of stage k.
  logic [NSTG:0]   valid;
  logic [TAGW-1:0] tag [NSTG+1];
  logic [W-1:0]    aj  [NSTG+1];
  logic [W-1:0]    ak  [NSTG+1];
  logic [AccW-1:0] acc [NSTG+1];

  assign valid[0] = i_valid;
  assign tag[0]   = i_tag;
  assign aj[0]    = i_aj;
  assign ak[0]    = i_ak;
  assign acc[0]   = '0;

  for (genvar k = 1; k <= NSTG; k++) begin : g_stage
    // Flush kills older operations only; a same-edge issue still enters stage 1.
    addr_mult_stage #(
      .W     (W),
      .PP    (PP),
      .TAGW  (TAGW),
      .AccW  (AccW),
      .Stage (k)
    ) u_stage (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .valid_i ((k == 1) ? valid[0] : (valid[k-1] & ~i_flush)),
      .tag_i   (tag[k-1]),
      .aj_i    (aj[k-1]),
      .ak_i    (ak[k-1]),
      .acc_i   (acc[k-1]),
      .valid_o (valid[k]),
      .tag_o   (tag[k]),
      .aj_o    (aj[k]),
      .ak_o    (ak[k]),
      .acc_o   (acc[k])
    );
  end

  assign o_valid  = valid[NSTG];
  assign o_result = acc[NSTG][W-1:0];
  assign o_tag    = tag[NSTG];
  assign o_busy   = |valid[NSTG:1];
`ifdef ADDR_MULT_OVF_EN
  assign o_ovf    = |acc[NSTG][AccW-1:W];
`endif

endmodule

// File: tb/tb_addr_mult_pipe.sv
// Randomized + directed bench for addr_mult_pipe against a queue-based product model.
module tb_addr_mult_pipe;
  import addr_mult_pkg::*;

  localparam int unsigned W    = ADDR_W;
  localparam int unsigned PP   = ADDR_PP;
  localparam int unsigned TAGW = ADDR_TAGW;
  localparam int          NSTG = W / PP;

  typedef struct {
    int              cyc;
    logic [W-1:0]    res;
    logic [TAGW-1:0] tag;
    logic            ovf;
  } op_t;

  logic            clk;
  logic            rst_n;
  logic            i_valid;
  logic [W-1:0]    i_aj;
  logic [W-1:0]    i_ak;
  logic [TAGW-1:0] i_tag;
  logic            i_flush;
  logic            o_valid;
  logic [W-1:0]    o_result;
  logic [TAGW-1:0] o_tag;
  logic            o_busy;
`ifdef ADDR_MULT_OVF_EN
  logic            o_ovf;
`endif

  // Second instance for the W=16, PP=8 sweep.
  logic        d2_valid_i;
  logic [15:0] d2_aj;
  logic [15:0] d2_ak;
  logic [2:0]  d2_tag_i;
  logic        d2_valid;
  logic [15:0] d2_result;
  logic [2:0]  d2_tag;
  logic        d2_busy;
`ifdef ADDR_MULT_OVF_EN
  logic        d2_ovf;
`endif

  addr_mult_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_aj     (i_aj),
    .i_ak     (i_ak),
    .i_tag    (i_tag),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_tag    (o_tag),
`ifdef ADDR_MULT_OVF_EN
    .o_ovf    (o_ovf),
`endif
    .o_busy   (o_busy)
  );

  addr_mult_pipe #(.W(16), .PP(8), .TAGW(3)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (d2_valid_i),
    .i_aj     (d2_aj),
    .i_ak     (d2_ak),
    .i_tag    (d2_tag_i),
    .i_flush  (1'b0),
    .o_valid  (d2_valid),
    .o_result (d2_result),
    .o_tag    (d2_tag),
`ifdef ADDR_MULT_OVF_EN
    .o_ovf    (d2_ovf),
`endif
    .o_busy   (d2_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Reference model: each issue becomes a pending product due NSTG-1 edges later.
  op_t             pend[$];
  op_t             nop;
  int              edge_n = 0;
  logic [63:0]     prod;
  logic            exp_valid, exp_busy, exp_ovf;
  logic [W-1:0]    exp_res;
  logic [TAGW-1:0] exp_tag;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
      exp_res   = '0;
      exp_tag   = '0;
      exp_ovf   = 1'b0;
    end else begin
      edge_n++;
      if (i_flush) pend.delete();
      if (i_valid) begin
        prod    = 64'(i_aj) * 64'(i_ak);
        nop.cyc = edge_n + NSTG - 1;
        nop.res = prod[W-1:0];
        nop.tag = i_tag;
        nop.ovf = (prod >> W) != 64'd0;
        pend.push_back(nop);
      end
      exp_busy  = pend.size() != 0;
      exp_valid = 1'b0;
      if (pend.size() != 0 && pend[0].cyc == edge_n) begin
        exp_valid = 1'b1;
        exp_res   = pend[0].res;
        exp_tag   = pend[0].tag;
        exp_ovf   = pend[0].ovf;
        void'(pend.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    check("o_valid", 64'(o_valid), 64'(exp_valid));
    check("o_busy", 64'(o_busy), 64'(exp_busy));
    check("o_result", 64'(o_result), 64'(exp_res));
    check("o_tag", 64'(o_tag), 64'(exp_tag));
`ifdef ADDR_MULT_OVF_EN
    check("o_ovf", 64'(o_ovf), 64'(exp_ovf));
`endif
  end

  // Retirement log for directed literal checks.
  op_t ret_q[$];
  op_t rop;
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      rop.cyc = cyc;
      rop.res = o_result;
      rop.tag = o_tag;
`ifdef ADDR_MULT_OVF_EN
      rop.ovf = o_ovf;
`else
      rop.ovf = 1'b0;
`endif
      ret_q.push_back(rop);
    end
  end

  task automatic issue(input logic [W-1:0] aj, input logic [W-1:0] ak,
                       input logic [TAGW-1:0] tag, input logic flush);
    i_valid = 1'b1;
    i_aj    = aj;
    i_ak    = ak;
    i_tag   = tag;
    i_flush = flush;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = '1;
      1:       v = W'($urandom_range(0, 15));
      default: v = W'($urandom());
    endcase
    return v;
  endfunction

  int c0;

  initial begin
    rst_n      = 1'b1;
    i_valid    = 1'b0;
    i_aj       = '0;
    i_ak       = '0;
    i_tag      = '0;
    i_flush    = 1'b0;
    d2_valid_i = 1'b0;
    d2_aj      = '0;
    d2_ak      = '0;
    d2_tag_i   = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset o_valid", 64'(o_valid), 64'd0);
    check("reset o_result", 64'(o_result), 64'd0);
    check("reset o_tag", 64'(o_tag), 64'd0);
    check("reset o_busy", 64'(o_busy), 64'd0);

    // Basic product
    ret_q.delete();
    issue(24'd3, 24'd5, 3'd2, 1'b0);
    c0 = cyc;
    idle(10);
    check("basic count", 64'(ret_q.size()), 64'd1);
    if (ret_q.size() >= 1) begin
      check("basic latency", 64'(ret_q[0].cyc - c0), 64'd5);
      check("basic result", 64'(ret_q[0].res), 64'd15);
      check("basic tag", 64'(ret_q[0].tag), 64'd2);
`ifdef ADDR_MULT_OVF_EN
      check("basic ovf", 64'(ret_q[0].ovf), 64'd0);
`endif
    end

    // Overflow
    ret_q.delete();
    issue(24'hFFFFFF, 24'hFFFFFF, 3'd6, 1'b0);
    idle(8);
    check("ovf count", 64'(ret_q.size()), 64'd1);
    if (ret_q.size() >= 1) begin
      check("ovf result", 64'(ret_q[0].res), 64'h000001);
`ifdef ADDR_MULT_OVF_EN
      check("ovf flag", 64'(ret_q[0].ovf), 64'd1);
`endif
    end

    // Streaming
    ret_q.delete();
    for (int k = 0; k < 8; k++) begin
      issue(W'(k + 1), 24'h1000, TAGW'(k), 1'b0);
      if (k == 0) c0 = cyc;
    end
    idle(10);
    check("stream count", 64'(ret_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < ret_q.size(); k++) begin
      check("stream cycle", 64'(ret_q[k].cyc - c0), 64'(5 + k));
      check("stream result", 64'(ret_q[k].res), 64'((k + 1) << 12));
      check("stream tag", 64'(ret_q[k].tag), 64'(k));
    end

    // Flush on the fourth issue edge
    ret_q.delete();
    for (int k = 0; k < 4; k++) issue(W'(100 + k), 24'd7, TAGW'(k + 4), k == 3);
    idle(8);
    check("flush count", 64'(ret_q.size()), 64'd1);
    if (ret_q.size() >= 1) begin
      check("flush tag", 64'(ret_q[0].tag), 64'd7);
      check("flush result", 64'(ret_q[0].res), 64'd721);
    end
    check("flush busy idle", 64'(o_busy), 64'd0);

    // Reset mid-flight
    ret_q.delete();
    for (int k = 0; k < 3; k++) issue(W'(9 + k), 24'd11, TAGW'(k + 1), 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst o_valid", 64'(o_valid), 64'd0);
    check("midrst o_busy", 64'(o_busy), 64'd0);
    check("midrst o_result", 64'(o_result), 64'd0);
    check("midrst o_tag", 64'(o_tag), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    check("midrst no retire", 64'(ret_q.size()), 64'd0);

    // Randomized traffic with occasional flushes
    for (int n = 0; n < 400; n++) begin
      i_valid = ($urandom_range(0, 99) < 65);
      i_flush = ($urandom_range(0, 99) < 5);
      i_aj    = rand_op();
      i_ak    = rand_op();
      i_tag   = TAGW'($urandom());
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_flush = 1'b0;
    idle(NSTG + 2);
    check("random drain busy", 64'(o_busy), 64'd0);

    // W=16, PP=8: two-stage latency
    d2_valid_i = 1'b1;
    d2_aj      = 16'hFFFF;
    d2_ak      = 16'h0002;
    d2_tag_i   = 3'd5;
    @(posedge clk);
    #1 d2_valid_i = 1'b0;
    check("sweep early valid", 64'(d2_valid), 64'd0);
    @(posedge clk);
    #1;
    check("sweep valid", 64'(d2_valid), 64'd1);
    check("sweep result", 64'(d2_result), 64'hFFFE);
    check("sweep tag", 64'(d2_tag), 64'd5);
`ifdef ADDR_MULT_OVF_EN
    check("sweep ovf", 64'(d2_ovf), 64'd1);
`endif
    @(posedge clk);
    #1;
    check("sweep pulse end", 64'(d2_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
